// File: rtl/pwm_out.sv
// pwm_out: gate-drive command generator for one H-bridge IGBT power unit.
//
// Produces registered gate commands for both legs from a 2-bit mode request.
// Dead time is inserted on every mode change, and a final guard stage keeps
// the upper and lower switch of a leg from ever being on together.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   err_unit     unit fault, active-high
//   start_stop   1 = run, 0 = stop
//   igbt_control mode select: 00 off, 01 right-upper, 10 left-upper, 11 both uppers
//   RUDIN/RDDIN  right leg upper/lower gate command
//   LUDIN/LDDIN  left leg upper/lower gate command
//
// Optional feature (macro FAULT_LATCH_EN): a rising err_unit latches the
// fault until start_stop is dropped for at least one cycle or rst_n asserts.
// Without the macro the fault simply follows err_unit.

module pwm_out #(
    parameter int unsigned PWM_PERIOD  = 1000,
    parameter int unsigned PWM_DUTY    = 500,
    parameter int unsigned DEAD_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       err_unit,
    input  logic       start_stop,
    input  logic [1:0] igbt_control,
    output logic       RUDIN,
    output logic       RDDIN,
    output logic       LUDIN,
    output logic       LDDIN
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DEAD_W = 8;

    typedef enum logic {
        ST_RUN,
        ST_DEAD
    } state_t;

    state_t              state;
    logic [1:0]          cur_mode;
    logic [DEAD_W-1:0]   dead_cnt;
    logic [CNT_W-1:0]    pwm_cnt;

    logic fault;
    logic run;
    logic pwm;
    logic pat_ru;
    logic pat_rd;
    logic pat_lu;
    logic pat_ld;

`ifdef FAULT_LATCH_EN
    logic fault_latch;
    logic err_prev;

    // Fault latch: set on a rising err_unit, released by a stop command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_latch <= 1'b0;
            err_prev    <= 1'b0;
        end else begin
            fault_latch <= (fault_latch & start_stop) | (err_unit & ~err_prev);
            err_prev    <= err_unit;
        end
    end

    assign fault = err_unit | fault_latch;
`else
    assign fault = err_unit;
`endif

    assign run = start_stop & ~fault;
    assign pwm = 32'(pwm_cnt) < PWM_DUTY;

    // Gate pattern for the applied mode, before the shoot-through guard.
    always_comb begin
        pat_ru = 1'b0;
        pat_rd = 1'b0;
        pat_lu = 1'b0;
        pat_ld = 1'b0;
        case (cur_mode)
            2'b01: begin
                pat_ru = 1'b1;
                pat_ld = pwm;
            end
            2'b10: begin
                pat_lu = 1'b1;
                pat_rd = pwm;
            end
            2'b11: begin
                pat_ru = 1'b1;
                pat_lu = 1'b1;
            end
            default: ;
        endcase
    end

    // Mode sequencer, carrier counter and registered gate outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            cur_mode <= 2'b00;
            dead_cnt <= '0;
            pwm_cnt  <= '0;
            RUDIN    <= 1'b0;
            RDDIN    <= 1'b0;
            LUDIN    <= 1'b0;
            LDDIN    <= 1'b0;
        end else begin
            if (pwm_cnt == CNT_W'(PWM_PERIOD - 1)) begin
                pwm_cnt <= '0;
            end else begin
                pwm_cnt <= pwm_cnt + CNT_W'(1);
            end

            RUDIN <= 1'b0;
            RDDIN <= 1'b0;
            LUDIN <= 1'b0;
            LDDIN <= 1'b0;

            if (!run) begin
                // Stopped or faulted: park in mode 00 so a restart re-enters via dead time.
                state    <= ST_RUN;
                cur_mode <= 2'b00;
                dead_cnt <= DEAD_W'(DEAD_CYCLES);
            end else begin
                case (state)
                    ST_RUN: begin
                        if (igbt_control != cur_mode) begin
                            state    <= ST_DEAD;
                            dead_cnt <= DEAD_W'(DEAD_CYCLES);
                        end else begin
                            // Lower is forced off whenever its leg's upper is on.
                            RUDIN <= pat_ru;
                            RDDIN <= pat_rd & ~pat_ru;
                            LUDIN <= pat_lu;
                            LDDIN <= pat_ld & ~pat_lu;
                        end
                    end
                    ST_DEAD: begin
                        // Request is sampled only at expiry, so late changes still win.
                        if (dead_cnt == '0) begin
                            cur_mode <= igbt_control;
                            pwm_cnt  <= '0;
                            state    <= ST_RUN;
                        end else begin
                            dead_cnt <= dead_cnt - DEAD_W'(1);
                        end
                    end
                    default: state <= ST_RUN;
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    a_no_shoot_right: assert property (@(posedge clk) disable iff (!rst_n) !(RUDIN && RDDIN));
    a_no_shoot_left:  assert property (@(posedge clk) disable iff (!rst_n) !(LUDIN && LDDIN));
`endif

endmodule

// File: tb/tb_pwm_out.sv
// tb_pwm_out: self-checking bench for pwm_out.
// A timestamp-based model predicts the gate outputs on every clock edge;
// directed steps add hand-computed expectations at key points.
// Output vectors are ordered {RUDIN, RDDIN, LUDIN, LDDIN}.

module tb_pwm_out;

    localparam int P    = 1000;
    localparam int DUTY = 500;
    localparam int D    = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_unit = 1'b0;
    logic       start_stop = 1'b0;
    logic [1:0] igbt_control = 2'b00;
    logic       RUDIN;
    logic       RDDIN;
    logic       LUDIN;
    logic       LDDIN;

    int checks = 0;
    int errors = 0;

    pwm_out #(
        .PWM_PERIOD (P),
        .PWM_DUTY   (DUTY),
        .DEAD_CYCLES(D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .err_unit    (err_unit),
        .start_stop  (start_stop),
        .igbt_control(igbt_control),
        .RUDIN       (RUDIN),
        .RDDIN       (RDDIN),
        .LUDIN       (LUDIN),
        .LDDIN       (LDDIN)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {RUDIN, RDDIN, LUDIN, LDDIN};
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Model state: edge index, applied mode, when the pattern started and when a pending request applies.
    int         n;
    int         apply_edge;
    int         start_edge;
    logic [1:0] m_mode;
    bit         pending;
    bit         m_latch;
    bit         m_err_prev;
    logic [3:0] exp_o;

    always @(posedge clk or negedge rst_n) begin
        bit m_fault;
        bit m_run;
        bit m_pwm;
        if (!rst_n) begin
            n          = 0;
            apply_edge = 0;
            start_edge = 0;
            m_mode     = 2'b00;
            pending    = 1'b0;
            m_latch    = 1'b0;
            m_err_prev = 1'b0;
        end else begin
`ifdef FAULT_LATCH_EN
            m_fault    = err_unit || m_latch;
            m_latch    = (m_latch && start_stop) || (err_unit && !m_err_prev);
            m_err_prev = err_unit;
`else
            m_fault    = err_unit;
`endif
            m_run = start_stop && !m_fault;
            exp_o = 4'b0000;
            if (!m_run) begin
                m_mode  = 2'b00;
                pending = 1'b0;
            end else if (pending) begin
                if (n == apply_edge) begin
                    m_mode     = igbt_control;
                    start_edge = n + 1;
                    pending    = 1'b0;
                end
            end else if (igbt_control != m_mode) begin
                pending    = 1'b1;
                apply_edge = n + D + 1;
            end else begin
                m_pwm = ((n - start_edge) % P) < DUTY;
                case (m_mode)
                    2'b01:   exp_o = {1'b1, 1'b0, 1'b0, m_pwm};
                    2'b10:   exp_o = {1'b0, m_pwm, 1'b1, 1'b0};
                    2'b11:   exp_o = 4'b1010;
                    default: exp_o = 4'b0000;
                endcase
            end
            n++;
            #1;
            chk("cycle_model", outs(), exp_o);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 4'b0000);
        rst_n        = 1'b1;
        start_stop   = 1'b1;
        igbt_control = 2'b00;
        repeat (P) @(negedge clk);
        chk("idle_00", outs(), 4'b0000);

        // Enter 01: dead time then right-upper with left-lower chopping.
        igbt_control = 2'b01;
        repeat (D + 2) @(negedge clk);
        chk("dead_01_end", outs(), 4'b0000);
        @(negedge clk);
        chk("enter_01", outs(), 4'b1001);
        repeat (DUTY - 1) @(negedge clk);
        chk("pwm_01_last_on", outs(), 4'b1001);
        @(negedge clk);
        chk("pwm_01_first_off", outs(), 4'b1000);
        repeat (P - DUTY) @(negedge clk);
        chk("pwm_01_wrap", outs(), 4'b1001);

        // 01 -> 10.
        igbt_control = 2'b10;
        @(negedge clk);
        chk("dead_10_first", outs(), 4'b0000);
        repeat (D + 1) @(negedge clk);
        chk("dead_10_end", outs(), 4'b0000);
        @(negedge clk);
        chk("enter_10", outs(), 4'b0110);
        repeat (DUTY) @(negedge clk);
        chk("pwm_10_off", outs(), 4'b0010);

        // 10 -> 11 freewheel, then back to 10.
        igbt_control = 2'b11;
        repeat (D + 2) @(negedge clk);
        chk("dead_11_end", outs(), 4'b0000);
        @(negedge clk);
        chk("enter_11", outs(), 4'b1010);
        repeat (200) @(negedge clk);
        chk("hold_11", outs(), 4'b1010);
        igbt_control = 2'b10;
        @(negedge clk);
        chk("dead_11_to_10", outs(), 4'b0000);
        repeat (D + 1) @(negedge clk);
        @(negedge clk);
        chk("reenter_10", outs(), 4'b0110);

        // Request changes mid dead time: no reload, latest request applied.
        repeat (50) @(negedge clk);
        igbt_control = 2'b11;
        repeat (5) @(negedge clk);
        igbt_control = 2'b01;
        repeat (D - 3) @(negedge clk);
        chk("late_change_dead", outs(), 4'b0000);
        @(negedge clk);
        chk("late_change_apply", outs(), 4'b1001);

        // One-cycle fault pulse while in 01.
        repeat (100) @(negedge clk);
        err_unit = 1'b1;
        @(negedge clk);
        err_unit = 1'b0;
        chk("fault_off", outs(), 4'b0000);
`ifdef FAULT_LATCH_EN
        repeat (D + 50) @(negedge clk);
        chk("fault_latched", outs(), 4'b0000);
        start_stop = 1'b0;
        @(negedge clk);
        start_stop = 1'b1;
        chk("fault_clear_stop", outs(), 4'b0000);
        repeat (D + 2) @(negedge clk);
        chk("fault_clear_dead", outs(), 4'b0000);
        @(negedge clk);
        chk("fault_clear_resume", outs(), 4'b1001);
`else
        repeat (D + 2) @(negedge clk);
        chk("fault_dead", outs(), 4'b0000);
        @(negedge clk);
        chk("fault_resume", outs(), 4'b1001);
`endif

        // Stop mid PWM, then restart through full dead time.
        repeat (123) @(negedge clk);
        start_stop = 1'b0;
        @(negedge clk);
        chk("stop_off", outs(), 4'b0000);
        start_stop = 1'b1;
        repeat (D + 2) @(negedge clk);
        chk("restart_dead", outs(), 4'b0000);
        @(negedge clk);
        chk("restart_resume", outs(), 4'b1001);

        // Asynchronous reset mid PWM.
        repeat (77) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", outs(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (D + 2) @(negedge clk);
        chk("post_reset_dead", outs(), 4'b0000);
        @(negedge clk);
        chk("post_reset_resume", outs(), 4'b1001);

        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
